// File: rtl/inertial_filter_if.sv
// Signal bundle between the inertial filter and its neighbours: raw input and
// counter clear in, filtered level, edge strobes, status and glitch count out.
interface inertial_filter_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             clr_cnt;
    logic             y;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [CNT_W-1:0] glitch_cnt;

    modport master (
        output a,
        output clr_cnt,
        input  y,
        input  rise,
        input  fall,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  a,
        input  clr_cnt,
        output y,
        output rise,
        output fall,
        output busy,
        output glitch_cnt
    );
endinterface

// File: rtl/inertial_filter.sv
// Inertial-delay filter: synchronises a raw bit and forwards a transition only
// after it has held for STABLE_CYCLES+1 samples; shorter pulses are counted.
module inertial_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inertial_filter_if.slave  bus
);
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             s1_q, s2_q;
    logic             y_q, y_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic             a_s;
    logic             reject_s;

    assign a_s = s2_q;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.a;
            s2_q <= s1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, run counter, output level and edge strobes.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        y_d       = y_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        reject_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_s != y_q) begin
                    state_d   = QUALIFY;
                    run_cnt_d = RUN_ONE;
                end else begin
                    run_cnt_d = RUN_ZERO;
                end
            end
            QUALIFY: begin
                // Returning to the current level before qualifying is a glitch.
                if (a_s == y_q) begin
                    reject_s  = 1'b1;
                    state_d   = IDLE;
                    run_cnt_d = RUN_ZERO;
                end else if (run_cnt_q == RUN_MAX) begin
                    y_d       = a_s;
                    rise_d    = a_s;
                    fall_d    = ~a_s;
                    state_d   = IDLE;
                    run_cnt_d = RUN_ZERO;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                run_cnt_d = RUN_ZERO;
            end
        endcase
        busy_d = (state_d == QUALIFY);
    end

    // Saturating glitch counter; a clear takes priority over a rejection.
    always_comb begin
        glitch_d = glitch_q;
        if (bus.clr_cnt) begin
            glitch_d = CNT_ZERO;
        end else if (reject_s && (glitch_q != CNT_MAX)) begin
            glitch_d = glitch_q + CNT_ONE;
        end else begin
            glitch_d = glitch_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= RUN_ZERO;
            y_q       <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            glitch_q  <= CNT_ZERO;
        end else begin
            run_cnt_q <= run_cnt_d;
            y_q       <= y_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
            glitch_q  <= glitch_d;
        end
    end

    assign bus.y          = y_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.busy       = busy_q;
    assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_inertial_filter.sv
// Directed bench for inertial_filter: one default instance (S=4, 8-bit count)
// and one with a 2-bit counter for saturation and clear-priority cases.
module tb_inertial_filter;
    logic clk;
    logic rst_n;
    int   vec;
    int   errs;

    inertial_filter_if #(.CNT_W(8)) bus8 ();
    inertial_filter_if #(.CNT_W(2)) bus2 ();

    inertial_filter #(.STABLE_CYCLES(4), .CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    inertial_filter #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vec          = 0;
        errs         = 0;
        rst_n        = 1'b0;
        bus8.a       = 1'b1;
        bus8.clr_cnt = 1'b0;
        bus2.a       = 1'b0;
        bus2.clr_cnt = 1'b0;

        // Reset held with a=1.
        tick();
        tick();
        tick();
        chk("rst_y",    32'(bus8.y), 32'd0);
        chk("rst_rf",   32'({bus8.rise, bus8.fall}), 32'd0);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_cnt",  32'(bus8.glitch_cnt), 32'd0);

        // Release with a=1: first edge after release is k, y rises on k+6.
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("pr_y",    32'(bus8.y),    (i >= 7) ? 32'd1 : 32'd0);
            chk("pr_rise", 32'(bus8.rise), (i == 7) ? 32'd1 : 32'd0);
            chk("pr_busy", 32'(bus8.busy), (i >= 3 && i <= 6) ? 32'd1 : 32'd0);
        end
        chk("pr_cnt", 32'(bus8.glitch_cnt), 32'd0);

        // Return to y=0.
        bus8.a = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            tick();
            chk("dn_y",    32'(bus8.y),    (j < 6) ? 32'd1 : 32'd0);
            chk("dn_fall", 32'(bus8.fall), (j == 6) ? 32'd1 : 32'd0);
        end

        // 4-cycle pulse: rejected, busy for 4 cycles.
        bus8.a = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            chk("p4_busy", 32'(bus8.busy), (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
            chk("p4_y",    32'(bus8.y), 32'd0);
            chk("p4_rf",   32'({bus8.rise, bus8.fall}), 32'd0);
            if (i == 3) bus8.a = 1'b0;
        end
        chk("p4_cnt", 32'(bus8.glitch_cnt), 32'd1);
        tick();
        tick();

        // 5-cycle pulse: passes, then falls 6 cycles after a returns low.
        bus8.a = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            tick();
            chk("p5_y",    32'(bus8.y),    (i >= 6 && i <= 10) ? 32'd1 : 32'd0);
            chk("p5_rise", 32'(bus8.rise), (i == 6) ? 32'd1 : 32'd0);
            chk("p5_fall", 32'(bus8.fall), (i == 11) ? 32'd1 : 32'd0);
            if (i == 4) bus8.a = 1'b0;
        end
        chk("p5_cnt", 32'(bus8.glitch_cnt), 32'd1);

        // 2-bit counter: five 1-cycle glitches read 1,2,3,3,3.
        for (int n = 1; n <= 5; n++) begin
            bus2.a = 1'b1;
            tick();
            bus2.a = 1'b0;
            for (int w = 0; w < 4; w++) tick();
            chk("sat_cnt", 32'(bus2.glitch_cnt), (n < 3) ? 32'(n) : 32'd3);
            chk("sat_y",   32'(bus2.y), 32'd0);
        end

        // Clear, then build count back to 2.
        bus2.clr_cnt = 1'b1;
        tick();
        bus2.clr_cnt = 1'b0;
        chk("clr_cnt", 32'(bus2.glitch_cnt), 32'd0);
        for (int n = 0; n < 2; n++) begin
            bus2.a = 1'b1;
            tick();
            bus2.a = 1'b0;
            for (int w = 0; w < 4; w++) tick();
        end
        chk("pre_clr", 32'(bus2.glitch_cnt), 32'd2);

        // Clear coincides with rejection edge k+3: clear wins.
        bus2.a = 1'b1;
        tick();
        bus2.a = 1'b0;
        tick();
        tick();
        chk("cw_busy", 32'(bus2.busy), 32'd1);
        bus2.clr_cnt = 1'b1;
        tick();
        bus2.clr_cnt = 1'b0;
        chk("cw_cnt",  32'(bus2.glitch_cnt), 32'd0);
        chk("cw_busy0", 32'(bus2.busy), 32'd0);
        tick();
        chk("cw_cnt2", 32'(bus2.glitch_cnt), 32'd0);
        tick();
        tick();

        // Toggle a every cycle on both instances: 50 one-cycle pulses.
        for (int i = 0; i < 100; i++) begin
            bus8.a = (i % 2 == 0) ? 1'b1 : 1'b0;
            bus2.a = bus8.a;
            tick();
            chk("tog_y8",  32'(bus8.y), 32'd0);
            chk("tog_rf8", 32'({bus8.rise, bus8.fall}), 32'd0);
            chk("tog_rf2", 32'({bus2.rise, bus2.fall}), 32'd0);
        end
        for (int w = 0; w < 4; w++) tick();
        chk("tog_cnt8", 32'(bus8.glitch_cnt), 32'd51);
        chk("tog_cnt2", 32'(bus2.glitch_cnt), 32'd3);
        chk("tog_y2",   32'(bus2.y), 32'd0);

        // Async reset mid-qualification at run_cnt=3.
        bus8.a = 1'b1;
        for (int i = 0; i <= 4; i++) tick();
        chk("mr_busy", 32'(bus8.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy0", 32'(bus8.busy), 32'd0);
        chk("mr_y",     32'(bus8.y), 32'd0);
        chk("mr_rf",    32'({bus8.rise, bus8.fall}), 32'd0);
        chk("mr_cnt8",  32'(bus8.glitch_cnt), 32'd0);
        chk("mr_cnt2",  32'(bus2.glitch_cnt), 32'd0);
        bus8.a = 1'b0;
        bus2.a = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_out", 32'({bus8.y, bus8.rise, bus8.fall, bus8.busy}), 32'd0);
        end
        chk("post_cnt", 32'(bus8.glitch_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
